// File: rtl/imem_responder_if.sv
// rtl/imem_responder_if.sv - fetch request/response bundle between fetch unit and instruction memory
interface imem_responder_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 9
);
   logic               req_valid;
   logic [ADDR_W-1:0]  req_addr;
   logic               req_ready;
   logic               flush;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [INSTR_W-1:0] rsp_instr;
   logic [ADDR_W-1:0]  rsp_addr;

   modport master (
      output req_valid, req_addr, flush, rsp_ready,
      input  req_ready, rsp_valid, rsp_instr, rsp_addr
   );

   modport slave (
      input  req_valid, req_addr, flush, rsp_ready,
      output req_ready, rsp_valid, rsp_instr, rsp_addr
   );
endinterface

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - single-outstanding instruction memory responder with fixed read latency
module imem_responder #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 9,
   parameter int LATENCY = 2
) (
   input  logic               f_clk,
   input  logic               rst_n,
   imem_responder_if.slave    fetch,
   input  logic               load_en,
   input  logic [ADDR_W-1:0]  load_addr,
   input  logic [INSTR_W-1:0] load_data,
   output logic               busy
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] LOAD_CNT = 4'(LATENCY - 1);

   state_t             state;
   state_t             state_next;
   logic [3:0]         cnt;
   logic [ADDR_W-1:0]  addr_q;
   logic [INSTR_W-1:0] rsp_instr_q;
   logic [ADDR_W-1:0]  rsp_addr_q;
   logic               req_ready;
   logic               accept;
   logic               capture;
   logic [ADDR_W-1:0]  cap_addr;
   logic [INSTR_W-1:0] cap_data;

   logic [INSTR_W-1:0] mem [2**ADDR_W];

   // Image storage is deliberately outside the reset domain so a reset keeps the program.
   always_ff @(posedge f_clk) begin
      if (load_en) begin
         mem[load_addr] <= load_data;
      end
   end

   assign accept  = fetch.req_valid & req_ready;
   assign capture = (state != RESP) && (state_next == RESP);

   // With LATENCY==1 the capture edge is the accept edge, so read from the live address.
   assign cap_addr = (state == IDLE) ? fetch.req_addr : addr_q;
   assign cap_data = (load_en && (load_addr == cap_addr)) ? load_data : mem[cap_addr];

   always_ff @(posedge f_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = (LATENCY == 1) ? RESP : READ;
            end
         end
         READ: begin
            if (fetch.flush) begin
               state_next = IDLE;
            end else if (cnt == 4'd1) begin
               state_next = RESP;
            end
         end
         RESP: begin
            if (fetch.flush || fetch.rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready       = (state == IDLE) & ~fetch.flush & ~load_en & rst_n;
      fetch.req_ready = req_ready;
      fetch.rsp_valid = (state == RESP);
      busy            = (state != IDLE);
   end

   always_ff @(posedge f_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= 4'd0;
         addr_q      <= '0;
         rsp_instr_q <= '0;
         rsp_addr_q  <= '0;
      end else begin
         if (accept) begin
            addr_q <= fetch.req_addr;
            cnt    <= LOAD_CNT;
         end else if (state == READ) begin
            cnt <= (state_next == READ) ? cnt - 4'd1 : 4'd0;
         end
         if (capture) begin
            rsp_instr_q <= cap_data;
            rsp_addr_q  <= cap_addr;
         end
      end
   end

   assign fetch.rsp_instr = rsp_instr_q;
   assign fetch.rsp_addr  = rsp_addr_q;
endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed checks of imem_responder at LATENCY 2 and LATENCY 1
module tb_imem_responder;
   logic       f_clk;
   logic       rst_n;
   logic       load_en;
   logic [7:0] load_addr;
   logic [8:0] load_data;
   logic       busy;
   logic       busy1;
   int         total;
   int         bad;

   imem_responder_if #(.ADDR_W(8), .INSTR_W(9)) f_if ();
   imem_responder_if #(.ADDR_W(8), .INSTR_W(9)) f1_if ();

   imem_responder #(.ADDR_W(8), .INSTR_W(9), .LATENCY(2)) u_dut (
      .f_clk     (f_clk),
      .rst_n     (rst_n),
      .fetch     (f_if.slave),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .busy      (busy)
   );

   imem_responder #(.ADDR_W(8), .INSTR_W(9), .LATENCY(1)) u_dut1 (
      .f_clk     (f_clk),
      .rst_n     (rst_n),
      .fetch     (f1_if.slave),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .busy      (busy1)
   );

   initial f_clk = 1'b0;
   always #5 f_clk = ~f_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge f_clk);
      #1;
   endtask

   task automatic load(input logic [7:0] a, input logic [8:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      tick();
      load_en   = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      load_en = 1'b0; load_addr = '0; load_data = '0;
      f_if.req_valid = 1'b0; f_if.req_addr = '0; f_if.flush = 1'b0; f_if.rsp_ready = 1'b0;
      f1_if.req_valid = 1'b0; f1_if.req_addr = '0; f1_if.flush = 1'b0; f1_if.rsp_ready = 1'b0;
      #3 rst_n = 1'b1;
      tick();

      load(8'h00, 9'h101);
      load(8'h01, 9'h0A5);
      load(8'h02, 9'h1FF);
      load(8'h03, 9'h000);
      load(8'hFF, 9'h0C3);

      // reset pulse between edges; memory must survive it
      rst_n = 1'b0;
      #2;
      check("rst_rsp_valid", f_if.rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_rsp_instr", f_if.rsp_instr, 0);
      check("rst_rsp_addr", f_if.rsp_addr, 0);
      check("rst_req_ready_low", f_if.req_ready, 0);
      #2 rst_n = 1'b1;
      #1;
      check("idle_req_ready", f_if.req_ready, 1);

      // basic read of 0x02
      f_if.req_valid = 1'b1; f_if.req_addr = 8'h02; f_if.rsp_ready = 1'b1;
      tick();
      f_if.req_valid = 1'b0;
      check("basic_t1_busy", busy, 1);
      check("basic_t1_valid", f_if.rsp_valid, 0);
      tick();
      check("basic_t2_valid", f_if.rsp_valid, 1);
      check("basic_t2_instr", f_if.rsp_instr, 9'h1FF);
      check("basic_t2_addr", f_if.rsp_addr, 8'h02);
      tick();
      check("basic_t3_valid", f_if.rsp_valid, 0);
      check("basic_t3_busy", busy, 0);
      check("basic_t3_ready", f_if.req_ready, 1);

      // backpressure on 0x01
      f_if.rsp_ready = 1'b0;
      f_if.req_valid = 1'b1; f_if.req_addr = 8'h01;
      tick();
      f_if.req_valid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", f_if.rsp_valid, 1);
         check("bp_instr", f_if.rsp_instr, 9'h0A5);
         check("bp_req_ready", f_if.req_ready, 0);
         tick();
      end
      f_if.rsp_ready = 1'b1;
      tick();
      check("bp_release_valid", f_if.rsp_valid, 0);
      check("bp_release_busy", busy, 0);

      // flush while reading 0x00
      f_if.req_valid = 1'b1; f_if.req_addr = 8'h00;
      tick();
      f_if.req_valid = 1'b0;
      f_if.flush = 1'b1;
      tick();
      f_if.flush = 1'b0;
      check("flush_read_busy", busy, 0);
      check("flush_read_valid", f_if.rsp_valid, 0);
      tick();
      check("flush_read_no_rsp", f_if.rsp_valid, 0);
      f_if.flush = 1'b1; f_if.req_valid = 1'b1; f_if.req_addr = 8'h03;
      #1;
      check("flush_idle_ready", f_if.req_ready, 0);
      tick();
      check("flush_idle_not_accepted", busy, 0);
      f_if.flush = 1'b0;
      tick();
      f_if.req_valid = 1'b0;
      tick();
      check("after_flush_valid", f_if.rsp_valid, 1);
      check("after_flush_instr", f_if.rsp_instr, 9'h000);
      check("after_flush_addr", f_if.rsp_addr, 8'h03);
      tick();

      // flush in RESP with rsp_ready high drops the response
      f_if.req_valid = 1'b1; f_if.req_addr = 8'h01;
      tick();
      f_if.req_valid = 1'b0;
      tick();
      check("flush_resp_pre_valid", f_if.rsp_valid, 1);
      f_if.flush = 1'b1;
      tick();
      f_if.flush = 1'b0;
      check("flush_resp_valid", f_if.rsp_valid, 0);
      check("flush_resp_busy", busy, 0);

      // load on the capture edge returns the new data; later load does not disturb it
      f_if.rsp_ready = 1'b0;
      f_if.req_valid = 1'b1; f_if.req_addr = 8'h01;
      tick();
      f_if.req_valid = 1'b0;
      load(8'h01, 9'h155);
      check("hazard_valid", f_if.rsp_valid, 1);
      check("hazard_instr", f_if.rsp_instr, 9'h155);
      load(8'h01, 9'h0AA);
      check("post_capture_instr", f_if.rsp_instr, 9'h155);
      f_if.rsp_ready = 1'b1;
      tick();
      check("hazard_done", busy, 0);

      // load blocks acceptance in IDLE
      load_en = 1'b1; load_addr = 8'h05; load_data = 9'h111;
      f_if.req_valid = 1'b1; f_if.req_addr = 8'h05;
      #1;
      check("load_blocks_ready", f_if.req_ready, 0);
      tick();
      check("load_blocks_accept", busy, 0);
      load_en = 1'b0;
      #1;
      check("load_drop_ready", f_if.req_ready, 1);
      tick();
      f_if.req_valid = 1'b0;
      check("load_drop_busy", busy, 1);
      tick();
      check("load_read_valid", f_if.rsp_valid, 1);
      check("load_read_instr", f_if.rsp_instr, 9'h111);
      tick();

      // async reset mid-READ aborts the request
      f_if.req_valid = 1'b1; f_if.req_addr = 8'h03;
      tick();
      f_if.req_valid = 1'b0;
      check("areset_pre_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("areset_valid", f_if.rsp_valid, 0);
      check("areset_busy", busy, 0);
      #2 rst_n = 1'b1;
      tick();
      check("areset_no_rsp1", f_if.rsp_valid, 0);
      tick();
      check("areset_no_rsp2", f_if.rsp_valid, 0);
      check("areset_idle", busy, 0);

      // top address
      f_if.req_valid = 1'b1; f_if.req_addr = 8'hFF;
      tick();
      f_if.req_valid = 1'b0;
      tick();
      check("wrap_valid", f_if.rsp_valid, 1);
      check("wrap_instr", f_if.rsp_instr, 9'h0C3);
      check("wrap_addr", f_if.rsp_addr, 8'hFF);
      tick();

      // LATENCY=1 build
      f1_if.rsp_ready = 1'b1;
      f1_if.req_valid = 1'b1; f1_if.req_addr = 8'h02;
      #1;
      check("lat1_req_ready", f1_if.req_ready, 1);
      tick();
      f1_if.req_valid = 1'b0;
      check("lat1_valid", f1_if.rsp_valid, 1);
      check("lat1_instr", f1_if.rsp_instr, 9'h1FF);
      check("lat1_addr", f1_if.rsp_addr, 8'h02);
      tick();
      check("lat1_idle", busy1, 0);
      check("lat1_done_valid", f1_if.rsp_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder on the far end of the fetch interface: accepts a PC-addressed fetch request and returns the 9-bit instruction at that address after a fixed read latency.
- Sits between the fetch unit (initiator) and decode.
- Holds one outstanding request, supports flush on taken branch/restart, and has a load port used by the bench/boot loader to fill the program image.

Parameters:
ADDR_W, 8, address width; memory depth is 2**ADDR_W words
INSTR_W, 9, instruction word width
LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15

Ports:
f_clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  1  fetch request present
req_addr  input  ADDR_W  PC to fetch
req_ready  output  1  responder can accept a request this cycle
flush  input  1  abort any in-flight or pending response
rsp_valid  output  1  rsp_instr/rsp_addr valid
rsp_ready  input  1  consumer accepts response
rsp_instr  output  INSTR_W  fetched instruction
rsp_addr  output  ADDR_W  address the instruction came from
load_en  input  1  write load_data into memory
load_addr  input  ADDR_W  write address
load_data  input  INSTR_W  write data
busy  output  1  state is not IDLE

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; rsp_valid=0, rsp_instr=0, rsp_addr=0, busy=0; latency counter=0.
  - Memory array is not reset; contents are retained across reset.
- State machine IDLE -> READ -> RESP -> IDLE.
- req_ready = (state==IDLE) & ~flush & ~load_en & rst_n. This is combinational from state and inputs.
- Handshake: a request is accepted when req_valid & req_ready at a rising edge (cycle T).
  - On acceptance, latch req_addr and load counter=LATENCY-1.
  - If LATENCY==1, go directly to RESP.
  - Otherwise go to READ.
- READ: the counter decrements each cycle. When counter==1, the next edge moves to RESP, reads mem[latched addr] into rsp_instr, and sets rsp_addr=latched addr and rsp_valid=1.
  - Net result: rsp_valid first visible in cycle T+LATENCY.
- RESP: rsp_valid=1; rsp_instr/rsp_addr held stable until rsp_valid & rsp_ready at an edge, then IDLE with rsp_valid=0.
  - Minimum request spacing is LATENCY+1 cycles; there is no request/response overlap.
- flush (highest priority after reset):
  - In READ or RESP: at the next edge go to IDLE with rsp_valid=0, discarding the response even if rsp_ready is high in the same cycle.
  - In IDLE: blocks acceptance (req_ready=0).
  - Has no effect on memory.
- load_en:
  - Writes mem[load_addr]=load_data at the edge, in any state.
  - The write also blocks request acceptance that cycle.
  - A write to the latched address before the READ->RESP edge is visible in rsp_instr (write-before-read).
  - A write on the same edge as the capture returns the new data.
  - A write after capture does not change the held rsp_instr.
- Address wrap: req_addr is used modulo 2**ADDR_W; no bounds error.
- busy = (state != IDLE).
- Reset asserted mid-READ/RESP: immediate return to reset values. No response is produced for the aborted request after rst_n deasserts.

Test Plan:
- Load mem[0x00..0x03]=0x101,0x0A5,0x1FF,0x000; reset; request 0x02 at T (LATENCY=2), rsp_ready=1 -> rsp_valid=1 at T+2 with rsp_instr=0x1FF, rsp_addr=0x02; IDLE at T+3, req_ready=1.
- Backpressure: request 0x01, hold rsp_ready=0 for 5 cycles -> rsp_valid stays 1, rsp_instr=0x0A5 stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
- Flush: accept 0x00 at T, flush=1 at T+1 -> rsp_valid never asserts, state IDLE at T+2; next request 0x03 returns 0x000.
- Flush in RESP with rsp_ready=1 same cycle -> response dropped, no handshake counted by bench, rsp_valid=0 next cycle.
- Load hazard: accept 0x01 at T, load_en writes 0x0A5->0x155 at address 0x01 in T+1 -> response 0x155; load_en with req_valid in IDLE -> req_ready=0, request not accepted until load_en drops.
- Async reset: assert rst_n=0 mid-READ between clock edges -> rsp_valid=0, busy=0 immediately; after release, request 0xFF wraps correctly and returns mem[0xFF]; LATENCY=1 build returns data at T+1.
